seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of scanned digits (1..4).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive identical samples required to capture a digit (>=1).
REQ-003 SHALL have port clock  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the synchronous, active-high reset.
REQ-005 SHALL have port digit_sel  input  NUM_DIGITS  meaning one-hot active-high digit select; bit 0 selects the least-significant digit.
REQ-006 SHALL have port segments  input  7  meaning the active-low segment pattern, bit6=g through bit0=a.
REQ-007 SHALL have port value  output  4*NUM_DIGITS  meaning the assembled hex value, digit i in bits [4i+3:4i].
REQ-008 SHALL have port err_mask  output  NUM_DIGITS  meaning a per-digit invalid-pattern flag for the held frame.
REQ-009 SHALL have port value_valid  output  1  meaning the held frame is available.
REQ-010 SHALL have port value_ready  input  1  meaning the consumer accepts the frame.
REQ-011 SHALL have port overrun  output  1  meaning sticky: a completed frame was dropped.

Function
REQ-012 Decode SHALL be: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F; any other pattern SHALL be invalid, nibble 0, error set.
REQ-013 A sample SHALL be qualified only when digit_sel is exactly one-hot; a non-one-hot sample SHALL clear the stability counter without capturing.
REQ-014 The stability counter SHALL increment while digit_sel and segments equal the previous cycle's values, and SHALL restart at 1 on any change.
REQ-015 A digit SHALL be captured exactly once per dwell, in the cycle the counter reaches STABLE_CYCLES; further identical cycles SHALL NOT recapture.
REQ-016 A capture SHALL write the nibble and error bit into the selected slot and set that slot's bit in the collected mask; recapturing an already-collected slot SHALL overwrite it.
REQ-017 The FSM SHALL have the states COLLECT (filling slots) and HOLD (value_valid=1, awaiting value_ready); capture SHALL continue in both states.
REQ-018 When the collected mask becomes all ones in COLLECT, value, err_mask and value_valid SHALL update on the next edge (1-cycle latency from the final capture), the FSM SHALL enter HOLD, and the mask SHALL clear.
REQ-019 In HOLD, value and err_mask SHALL stay stable until value_valid && value_ready, after which the FSM SHALL return to COLLECT.
REQ-020 If a frame completes in HOLD without a handshake in that cycle, the frame SHALL be dropped, the mask cleared and overrun set; with a handshake in the same cycle the new frame SHALL load and HOLD SHALL persist.
REQ-021 overrun SHALL remain 1 until reset.

Reset
REQ-022 Reset SHALL force COLLECT, a zero counter, a zero mask, value=0, err_mask=0, value_valid=0 and overrun=0 on the next edge, aborting any partial frame or held value.
REQ-023 Reset SHALL take priority over capture and the handshake in the same cycle.

Configuration
REQ-024 With SEG7_BLANK_DETECT_EN defined, pattern 1111111 SHALL decode as a valid blank (nibble 0, no error) and a blank_mask output (NUM_DIGITS, reset 0, held with value) SHALL flag blank digits.
REQ-025 Without SEG7_BLANK_DETECT_EN, 1111111 SHALL be invalid per REQ-012 and blank_mask SHALL not exist.

Structure
REQ-026 Package seg7_pkg SHALL hold the 16 pattern constants, SEG_BLANK, and the FSM state typedef.
REQ-027 The combinational pattern-to-nibble decode SHALL be the sub-module seg7_to_binary (ports: segments in, nibble out, invalid out, blank out).

Verification
REQ-028 Scan 0001/0010/0100/1000 with 0000010, 0010000, 0001000, 1000000 held 4 cycles each, value_ready=1 -> value=0x0A96, err_mask=0, value_valid one cycle after the 4th capture.
REQ-029 Scan a digit dwelling 3 cycles (STABLE_CYCLES=4) -> no capture, value_valid stays 0; a repeat dwell of 4 captures it.
REQ-030 digit 2 carries 0101010 -> err_mask=0100, nibble 2 = 0.
REQ-031 Hold value_ready=0 and complete two frames -> the first frame is held unchanged and overrun=1; raise value_ready -> value_valid drops the next cycle.
REQ-032 digit_sel=0011 for 10 cycles -> no capture; assert reset mid-frame -> all outputs 0 and the partial mask is discarded.
REQ-033 With SEG7_BLANK_DETECT_EN, digit 3 carries 1111111 -> blank_mask=1000, err_mask=0; without the macro -> err_mask=1000.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: the active-low glyph
// patterns (bit6=g .. bit0=a), the blank pattern and the frame FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Frame FSM: COLLECT fills slots, HOLD presents a frame to the consumer.
  typedef logic [0:0] state_t;
  localparam state_t COLLECT = 1'b0;
  localparam state_t HOLD    = 1'b1;

endpackage

// File: rtl/seg7_to_binary.sv
// Combinational active-low segment pattern to hex nibble decode.
// blank flags the all-off pattern; invalid flags any pattern that is neither a
// hex glyph nor blank. The parent decides whether blank counts as an error.
module seg7_to_binary
  import seg7_pkg::*;
(
  input  logic [6:0] segments,
  output logic [3:0] nibble,
  output logic       invalid,
  output logic       blank
);

  // Table lookup; unknown patterns decode to nibble 0.
  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    blank   = (segments == SEG_BLANK);
    case (segments)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: invalid = (segments != SEG_BLANK);
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a hex value from a multiplexed seven-segment display scan.
// Each digit is captured once after STABLE_CYCLES identical one-hot samples;
// a full set of digits forms a frame presented with a valid/ready handshake.
// Optional feature: define SEG7_BLANK_DETECT_EN to treat the all-off pattern
// as a valid blank digit and expose blank_mask.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic [6:0]              segments,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   err_mask,
`ifdef SEG7_BLANK_DETECT_EN
  output logic [NUM_DIGITS-1:0]   blank_mask,
`endif
  output logic                    value_valid,
  input  logic                    value_ready,
  output logic                    overrun
);

  // Counter saturates one past the capture point so a long dwell never recaptures.
  localparam int unsigned CntMax = STABLE_CYCLES + 1;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic [NUM_DIGITS-1:0]   sel_q;
  logic [6:0]              seg_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    sel_onehot, same_sample, capture;

  logic [3:0]              dec_nibble;
  logic                    dec_invalid, dec_blank, cap_err;

  logic [4*NUM_DIGITS-1:0] slot_nib_q, slot_nib_d;
  logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_full, handshake, load;

  seg7_to_binary u_dec (
    .segments (segments),
    .nibble   (dec_nibble),
    .invalid  (dec_invalid),
    .blank    (dec_blank)
  );

`ifdef SEG7_BLANK_DETECT_EN
  logic [NUM_DIGITS-1:0] slot_blank_q, slot_blank_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  assign cap_err    = dec_invalid;
  assign blank_mask = blank_q;
`else
  assign cap_err = dec_invalid | dec_blank;
`endif

  assign sel_onehot  = $onehot(digit_sel);
  assign same_sample = (digit_sel == sel_q) && (segments == seg_q);
  assign capture     = sel_onehot && (cnt_d == CntW'(STABLE_CYCLES));
  assign frame_full  = &mask_q;
  assign handshake   = valid_q && value_ready;

  // Dwell length of the current sample; zero while the select is not one-hot.
  always_comb begin
    cnt_d = cnt_q;
    if (!sel_onehot) begin
      cnt_d = '0;
    end else if (same_sample) begin
      if (cnt_q != CntW'(CntMax)) cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = CntW'(1);
    end
  end

  // Write the captured digit into the slot chosen by the one-hot select.
  always_comb begin
    slot_nib_d = slot_nib_q;
    slot_err_d = slot_err_q;
`ifdef SEG7_BLANK_DETECT_EN
    slot_blank_d = slot_blank_q;
`endif
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (capture && digit_sel[i]) begin
        slot_nib_d[4*i +: 4] = dec_nibble;
        slot_err_d[i]        = cap_err;
`ifdef SEG7_BLANK_DETECT_EN
        slot_blank_d[i]      = dec_blank;
`endif
      end
    end
  end

  // Frame FSM: a full mask loads or drops a frame; a capture in the same
  // cycle counts toward the next frame.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    mask_d    = mask_q;
    load      = 1'b0;
    if (frame_full) begin
      mask_d = '0;
      if (state_q == COLLECT || handshake) begin
        load    = 1'b1;
        state_d = HOLD;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (state_q == HOLD && handshake) begin
      state_d = COLLECT;
      valid_d = 1'b0;
    end
    if (capture) mask_d = mask_d | digit_sel;
    value_d = load ? slot_nib_q : value_q;
    err_d   = load ? slot_err_q : err_q;
`ifdef SEG7_BLANK_DETECT_EN
    blank_d = load ? slot_blank_q : blank_q;
`endif
  end

  // Sample history and dwell counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q <= '0;
      seg_q <= '0;
      cnt_q <= '0;
    end else begin
      sel_q <= digit_sel;
      seg_q <= segments;
      cnt_q <= cnt_d;
    end
  end

  // Digit slot storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_nib_q <= '0;
      slot_err_q <= '0;
`ifdef SEG7_BLANK_DETECT_EN
      slot_blank_q <= '0;
`endif
    end else begin
      slot_nib_q <= slot_nib_d;
      slot_err_q <= slot_err_d;
`ifdef SEG7_BLANK_DETECT_EN
      slot_blank_q <= slot_blank_d;
`endif
    end
  end

  // FSM state, collected mask and held frame outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= COLLECT;
      mask_q    <= '0;
      value_q   <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SEG7_BLANK_DETECT_EN
      blank_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef SEG7_BLANK_DETECT_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign value       = value_q;
  assign err_mask    = err_q;
  assign value_valid = valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with a frame-level reference model.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  // Glyph table 0..F, independent of the design package.
  localparam logic [6:0] TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] JUNK  = 7'b0101010;

  logic            clock = 1'b0;
  logic            reset;
  logic [ND-1:0]   digit_sel;
  logic [6:0]      segments;
  logic [4*ND-1:0] value;
  logic [ND-1:0]   err_mask;
  logic            value_valid;
  logic            value_ready;
  logic            overrun;
`ifdef SEG7_BLANK_DETECT_EN
  logic [ND-1:0]   blank_mask;
`endif

  always #5 clock = ~clock;

  seg7_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .digit_sel   (digit_sel),
    .segments    (segments),
    .value       (value),
    .err_mask    (err_mask),
`ifdef SEG7_BLANK_DETECT_EN
    .blank_mask  (blank_mask),
`endif
    .value_valid (value_valid),
    .value_ready (value_ready),
    .overrun     (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digits are remembered per position, a frame is the set
  // of all positions, and completed frames are handed off one edge later.
  int              run;
  logic [ND-1:0]   last_sel;
  logic [6:0]      last_seg;
  int              m_nib [ND];
  bit              m_err [ND];
  bit              m_blk [ND];
  bit              coll  [ND];
  bit              m_valid, m_over, started;
  logic [4*ND-1:0] m_value;
  logic [ND-1:0]   m_errm, m_blkm;

  task automatic model_decode(input logic [6:0] s, output int nib, output bit err,
                              output bit blk);
    nib = 0;
    err = 1'b1;
    blk = 1'b0;
    for (int k = 0; k < 16; k++) if (s == TBL[k]) begin
      nib = k;
      err = 1'b0;
    end
`ifdef SEG7_BLANK_DETECT_EN
    if (s == BLANK) begin
      err = 1'b0;
      blk = 1'b1;
    end
`endif
  endtask

  task automatic model_clear();
    run = 0; last_sel = '0; last_seg = '0;
    m_valid = 1'b0; m_over = 1'b0; m_value = '0; m_errm = '0; m_blkm = '0;
    for (int i = 0; i < ND; i++) begin
      m_nib[i] = 0; m_err[i] = 1'b0; m_blk[i] = 1'b0; coll[i] = 1'b0;
    end
  endtask

  always @(posedge clock) begin
    bit onehot, full, e, b;
    int n;
    started = 1'b1;
    if (reset) begin
      model_clear();
    end else begin
      onehot = ($countones(digit_sel) == 1);
      if (!onehot) run = 0;
      else if (digit_sel == last_sel && segments == last_seg) run++;
      else run = 1;
      last_sel = digit_sel;
      last_seg = segments;
      full = 1'b1;
      for (int i = 0; i < ND; i++) if (!coll[i]) full = 1'b0;
      if (full) begin
        for (int i = 0; i < ND; i++) coll[i] = 1'b0;
        if (!m_valid || value_ready) begin
          m_valid = 1'b1;
          for (int i = 0; i < ND; i++) begin
            m_value[4*i +: 4] = 4'(m_nib[i]);
            m_errm[i] = m_err[i];
            m_blkm[i] = m_blk[i];
          end
        end else begin
          m_over = 1'b1;
        end
      end else if (m_valid && value_ready) begin
        m_valid = 1'b0;
      end
      if (onehot && run == SC) begin
        model_decode(segments, n, e, b);
        for (int i = 0; i < ND; i++) if (digit_sel[i]) begin
          m_nib[i] = n; m_err[i] = e; m_blk[i] = b; coll[i] = 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (started) begin
      chk("model value", 32'(value), 32'(m_value));
      chk("model err_mask", 32'(err_mask), 32'(m_errm));
      chk("model value_valid", 32'(value_valid), 32'(m_valid));
      chk("model overrun", 32'(overrun), 32'(m_over));
`ifdef SEG7_BLANK_DETECT_EN
      chk("model blank_mask", 32'(blank_mask), 32'(m_blkm));
`endif
    end
  end

  task automatic cyc(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
    digit_sel = sel;
    segments  = seg;
    repeat (n) @(negedge clock);
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3);
    cyc(4'b0001, s0, SC);
    cyc(4'b0010, s1, SC);
    cyc(4'b0100, s2, SC);
    cyc(4'b1000, s3, SC);
    cyc(4'b0000, BLANK, 1);
  endtask

  task automatic ack();
    value_ready = 1'b1;
    @(negedge clock);
    value_ready = 1'b0;
    chk("ack drops valid", 32'(value_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    started     = 1'b0;
    model_clear();
    reset       = 1'b1;
    digit_sel   = '0;
    segments    = BLANK;
    value_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("reset value", 32'(value), 32'd0);
    chk("reset valid", 32'(value_valid), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);

    // Basic scan with the consumer always ready.
    value_ready = 1'b1;
    frame(TBL[6], TBL[9], TBL[10], TBL[0]);
    chk("scan valid", 32'(value_valid), 32'd1);
    chk("scan value", 32'(value), 32'h0A96);
    chk("scan err", 32'(err_mask), 32'd0);
    @(negedge clock);
    chk("scan valid drop", 32'(value_valid), 32'd0);
    value_ready = 1'b0;

    // Short dwell does not capture; a full repeat dwell does.
    cyc(4'b0001, TBL[1], SC - 1);
    cyc(4'b0010, TBL[2], SC);
    cyc(4'b0100, TBL[3], SC);
    cyc(4'b1000, TBL[4], SC);
    cyc(4'b0000, BLANK, 2);
    chk("short dwell no frame", 32'(value_valid), 32'd0);
    cyc(4'b0001, TBL[7], SC);
    cyc(4'b0000, BLANK, 1);
    chk("redwell valid", 32'(value_valid), 32'd1);
    chk("redwell value", 32'(value), 32'h4327);
    ack();

    // Invalid pattern on digit 2; long dwell on digit 0 must not recapture.
    cyc(4'b0001, TBL[14], 3 * SC);
    cyc(4'b0010, TBL[11], SC);
    cyc(4'b0100, JUNK, SC);
    cyc(4'b1000, TBL[12], SC);
    cyc(4'b0000, BLANK, 1);
    chk("invalid value", 32'(value), 32'hC0BE);
    chk("invalid err", 32'(err_mask), 32'b0100);
    ack();

    // Second frame while the first is held is dropped and flags overrun.
    frame(TBL[1], TBL[2], TBL[3], TBL[4]);
    chk("held value", 32'(value), 32'h4321);
    frame(TBL[5], TBL[6], TBL[7], TBL[8]);
    chk("overrun value", 32'(value), 32'h4321);
    chk("overrun valid", 32'(value_valid), 32'd1);
    chk("overrun flag", 32'(overrun), 32'd1);
    ack();
    chk("overrun sticky", 32'(overrun), 32'd1);

    // Non-one-hot select never captures; reset discards the partial frame.
    cyc(4'b0011, TBL[8], 10);
    cyc(4'b0000, BLANK, 2);
    chk("non-onehot no frame", 32'(value_valid), 32'd0);
    cyc(4'b0001, TBL[5], SC);
    cyc(4'b0010, TBL[5], SC);
    do_reset();
    chk("mid reset value", 32'(value), 32'd0);
    chk("mid reset err", 32'(err_mask), 32'd0);
    chk("mid reset valid", 32'(value_valid), 32'd0);
    chk("mid reset overrun", 32'(overrun), 32'd0);
    cyc(4'b0100, TBL[1], SC);
    cyc(4'b1000, TBL[2], SC);
    cyc(4'b0000, BLANK, 2);
    chk("partial discarded", 32'(value_valid), 32'd0);

    // Blank pattern on digit 3.
    do_reset();
    frame(TBL[1], TBL[2], TBL[3], BLANK);
    chk("blank value", 32'(value), 32'h0321);
`ifdef SEG7_BLANK_DETECT_EN
    chk("blank mask", 32'(blank_mask), 32'b1000);
    chk("blank err", 32'(err_mask), 32'd0);
`else
    chk("blank err", 32'(err_mask), 32'b1000);
`endif
    ack();

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
